// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor bit per clock, borrow carried in a flip-flop.
// Operands are captured on start; diff/borrow_out/ovf update only at completion and pulse done.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf,
    output logic             sbit,
    output logic             sbit_valid
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_d_sh;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_ovf;
    logic             r_sbit;
    logic             r_sbit_valid;

    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_bo;
    logic [WIDTH-1:0] w_d_next;

    assign w_x  = r_a_sh[0];
    assign w_y  = r_b_sh[0];
    assign w_d  = w_x ^ w_y ^ r_borrow;
    assign w_bo = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
    // New difference bit enters at the MSB so the last bit lands the word in place.
    assign w_d_next = (r_d_sh >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_d_sh       <= '0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            r_done       <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_ovf        <= 1'b0;
            r_sbit       <= 1'b0;
            r_sbit_valid <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_sbit_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= SHIFT;
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_d_sh   <= '0;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
                    end
                end
                SHIFT: begin
                    r_a_sh       <= r_a_sh >> 1;
                    r_b_sh       <= r_b_sh >> 1;
                    r_d_sh       <= w_d_next;
                    r_borrow     <= w_bo;
                    r_cnt        <= r_cnt + CNT_W'(1);
                    r_sbit       <= w_d;
                    r_sbit_valid <= 1'b1;
                    if (r_cnt == LAST) begin
                        r_state      <= IDLE;
                        r_diff       <= w_d_next;
                        r_borrow_out <= w_bo;
                        r_done       <= 1'b1;
                        // Signed overflow: operand signs differ and result sign differs from minuend.
                        r_ovf        <= (r_a_msb ^ r_b_msb) & (w_d_next[WIDTH-1] ^ r_a_msb);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = (r_state == SHIFT);
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign ovf        = r_ovf;
    assign sbit       = r_sbit;
    assign sbit_valid = r_sbit_valid;

endmodule
